// File: rtl/eic_sense_bank_if.sv
// Register port between the bus bridge and eic_sense_bank.
//   reg_wr    : write strobe, the write takes effect at the edge it is sampled
//   reg_rd    : read strobe, reg_rdata is valid the following cycle
//   reg_addr  : word address (0..7)
//   reg_wdata : write data
//   reg_rdata : registered read data, holds until the next read
interface eic_sense_bank_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/eic_sense_bank.sv
// External interrupt controller for the MIPSfpga+ EIC interface.
// Per-channel input synchroniser, programmable sense mode, mask, and a pending
// register with software set / write-1-to-clear.  A registered priority
// encoder presents the highest pending unmasked channel as EIC_Vector.
//   CLK           : clock
//   RESET         : synchronous active-high reset
//   signal        : raw interrupt inputs, one per channel
//   irq_ack       : core accepts the presented vector, clears its flag
//   bus           : word-addressed register port (slave side)
//   EIC_Interrupt : {2'b00, EIC_Vector}
//   EIC_Vector    : winning channel index + 1, 0 when nothing is requested
module eic_sense_bank #(
    parameter int unsigned CHANNELS    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] signal,
    input  logic                irq_ack,
    eic_sense_bank_if.slave     bus,
    output logic [7:0]          EIC_Interrupt,
    output logic [5:0]          EIC_Vector
);

    localparam int unsigned SENSE_W = 2 * CHANNELS;
    localparam int unsigned GUARD_W = 3;
    localparam int unsigned VEC_W   = 6;

    localparam logic [2:0] ADDR_MASK    = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_SET     = 3'd2;
    localparam logic [2:0] ADDR_SENSE0  = 3'd3;
    localparam logic [2:0] ADDR_SENSE1  = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    localparam logic [1:0] SENSE_LEVEL = 2'b00;
    localparam logic [1:0] SENSE_ANY   = 2'b01;
    localparam logic [1:0] SENSE_FALL  = 2'b10;
    localparam logic [1:0] SENSE_RISE  = 2'b11;

    // state
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0]                  prev_q, prev_d;
    logic [CHANNELS-1:0]                  mask_q, mask_d;
    logic [CHANNELS-1:0]                  pend_q, pend_d;
    logic [SENSE_W-1:0]                   sense_q, sense_d;
    logic [VEC_W-1:0]                     vec_q, vec_d;
    logic [31:0]                          rdata_q, rdata_d;
    logic [GUARD_W-1:0]                   guard_q, guard_d;

    // combinational helpers
    logic [CHANNELS-1:0] sync_last;
    logic [CHANNELS-1:0] sense_match;
    logic [CHANNELS-1:0] pend_set;
    logic [CHANNELS-1:0] pend_clr;
    logic [CHANNELS-1:0] ack_clr;
    logic [63:0]         sense_ext;
    logic [63:0]         sense_new;
    logic                edge_en;
    logic                wr_mask, wr_pend, wr_set, wr_sense0, wr_sense1;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign sense_ext = 64'(sense_q);
    // Edge detection stays off until the synchroniser and prev have filled.
    assign edge_en   = (guard_q == '0);

    assign wr_mask   = bus.reg_wr && (bus.reg_addr == ADDR_MASK);
    assign wr_pend   = bus.reg_wr && (bus.reg_addr == ADDR_PENDING);
    assign wr_set    = bus.reg_wr && (bus.reg_addr == ADDR_SET);
    assign wr_sense0 = bus.reg_wr && (bus.reg_addr == ADDR_SENSE0);
    assign wr_sense1 = bus.reg_wr && (bus.reg_addr == ADDR_SENSE1);

    // Input synchroniser shift and edge history.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = signal;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_last;
    end

    // Post-reset edge guard countdown.
    always_comb begin
        guard_d = guard_q;
        if (guard_q != '0) begin
            guard_d = guard_q - GUARD_W'(1);
        end
    end

    // Per-channel sense decode.
    always_comb begin
        sense_match = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            unique case (sense_q[2*i +: 2])
                SENSE_LEVEL: sense_match[i] = sync_last[i];
                SENSE_ANY:   sense_match[i] = edge_en & (sync_last[i] ^ prev_q[i]);
                SENSE_FALL:  sense_match[i] = edge_en & ~sync_last[i] & prev_q[i];
                SENSE_RISE:  sense_match[i] = edge_en & sync_last[i] & ~prev_q[i];
                default:     sense_match[i] = 1'b0;
            endcase
        end
    end

    // Acknowledge clears only the channel currently presented.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (irq_ack && (vec_q == VEC_W'(i + 1))) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // Pending update: any set source beats any clear source.
    always_comb begin
        pend_set = mask_q & sense_match;
        pend_clr = ack_clr;
        if (wr_set) begin
            pend_set = pend_set | bus.reg_wdata[CHANNELS-1:0];
        end
        if (wr_pend) begin
            pend_clr = pend_clr | bus.reg_wdata[CHANNELS-1:0];
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // Software-writable configuration.
    always_comb begin
        mask_d    = mask_q;
        sense_new = sense_ext;
        if (wr_mask) begin
            mask_d = bus.reg_wdata[CHANNELS-1:0];
        end
        if (wr_sense0) begin
            sense_new[31:0] = bus.reg_wdata;
        end
        if (wr_sense1) begin
            sense_new[63:32] = bus.reg_wdata;
        end
        sense_d = sense_new[SENSE_W-1:0];
    end

    // Priority encoder: highest qualifying channel wins.
    always_comb begin
        vec_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pend_q[i] && mask_q[i]) begin
                vec_d = VEC_W'(i + 1);
            end
        end
    end

    // Read mux samples pre-write state so read+write returns the old value.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.reg_rd) begin
            unique case (bus.reg_addr)
                ADDR_MASK:    rdata_d = 32'(mask_q);
                ADDR_PENDING: rdata_d = 32'(pend_q);
                ADDR_SENSE0:  rdata_d = sense_ext[31:0];
                ADDR_SENSE1:  rdata_d = sense_ext[63:32];
                ADDR_STATUS:  rdata_d = 32'(vec_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q  <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            sense_q <= '0;
            vec_q   <= '0;
            rdata_q <= '0;
            guard_q <= GUARD_W'(SYNC_STAGES + 1);
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            sense_q <= sense_d;
            vec_q   <= vec_d;
            rdata_q <= rdata_d;
            guard_q <= guard_d;
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign EIC_Vector    = vec_q;
    assign EIC_Interrupt = {2'b00, vec_q};

endmodule

// File: tb/tb_eic_sense_bank.sv
// Self-checking bench for eic_sense_bank (default parameters).
module tb_eic_sense_bank;

    logic        CLK;
    logic        RESET;
    logic [31:0] sig;
    logic        irq_ack;
    logic [7:0]  EIC_Interrupt;
    logic [5:0]  EIC_Vector;

    int n_tests;
    int n_fail;

    eic_sense_bank_if bus_if ();

    eic_sense_bank #(
        .CHANNELS    (32),
        .SYNC_STAGES (2)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .signal        (sig),
        .irq_ack       (irq_ack),
        .bus           (bus_if.slave),
        .EIC_Interrupt (EIC_Interrupt),
        .EIC_Vector    (EIC_Vector)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] set;
        logic [31:0] exp_pend;
        logic [5:0]  exp_vec;
    } pend_vec_t;

    reg_vec_t  reg_tbl[8];
    pend_vec_t pend_tbl[6];

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        tick();
        bus_if.reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = a;
        tick();
        bus_if.reg_rd   = 1'b0;
        d = bus_if.reg_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;

        reg_tbl[0] = '{3'd0, 32'h1234_5678, 32'h1234_5678};
        reg_tbl[1] = '{3'd3, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        reg_tbl[2] = '{3'd4, 32'h0F0F_F0F0, 32'h0F0F_F0F0};
        reg_tbl[3] = '{3'd2, 32'h0000_0000, 32'h0000_0000};
        reg_tbl[4] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
        reg_tbl[5] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
        reg_tbl[6] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
        reg_tbl[7] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0000};

        pend_tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 6'd1};
        pend_tbl[1] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 6'd32};
        pend_tbl[2] = '{32'h0000_00FF, 32'h8000_0010, 32'h8000_0010, 6'd5};
        pend_tbl[3] = '{32'h0000_0000, 32'h0000_0400, 32'h0000_0400, 6'd0};
        pend_tbl[4] = '{32'h7FFF_FFFF, 32'hC000_0000, 32'hC000_0000, 6'd31};
        pend_tbl[5] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd17};

        n_tests = 0;
        n_fail  = 0;
        sig     = '0;
        irq_ack = 1'b0;
        bus_if.reg_wr    = 1'b0;
        bus_if.reg_rd    = 1'b0;
        bus_if.reg_addr  = '0;
        bus_if.reg_wdata = '0;
        RESET   = 1'b1;
        @(negedge CLK);
        tick();
        tick();

        // Reset defaults
        check("rst_vec", 32'(EIC_Vector), 32'd0);
        check("rst_int", 32'(EIC_Interrupt), 32'd0);
        check("rst_rdata", bus_if.reg_rdata, 32'd0);
        RESET = 1'b0;
        sig   = 32'hFFFF_FFFF;
        repeat (5) tick();
        check("unmasked_vec", 32'(EIC_Vector), 32'd0);
        rd(3'd1, d);
        check("unmasked_pend", d, 32'd0);
        sig = '0;
        repeat (4) tick();

        // Register map
        for (int i = 0; i < 8; i++) begin
            wr(reg_tbl[i].addr, reg_tbl[i].wdata);
            rd(reg_tbl[i].addr, d);
            check($sformatf("regmap_%0d", i), d, reg_tbl[i].exp_rd);
        end

        // Read and write to the same address in one cycle return the old value.
        bus_if.reg_rd    = 1'b1;
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = 3'd0;
        bus_if.reg_wdata = 32'hCAFE_F00D;
        tick();
        bus_if.reg_rd = 1'b0;
        bus_if.reg_wr = 1'b0;
        check("rw_same_cycle", bus_if.reg_rdata, 32'h1234_5678);
        tick();
        check("rdata_hold", bus_if.reg_rdata, 32'h1234_5678);
        rd(3'd0, d);
        check("rw_new_value", d, 32'hCAFE_F00D);

        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        repeat (4) tick();

        // Software set / mask / encoder
        for (int i = 0; i < 6; i++) begin
            wr(3'd1, 32'hFFFF_FFFF);
            wr(3'd0, pend_tbl[i].mask);
            wr(3'd2, pend_tbl[i].set);
            tick();
            check($sformatf("enc_vec_%0d", i), 32'(EIC_Vector), 32'(pend_tbl[i].exp_vec));
            rd(3'd1, d);
            check($sformatf("enc_pend_%0d", i), d, pend_tbl[i].exp_pend);
        end

        // Masked flag is hidden, then re-presented when unmasked.
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0);
        wr(3'd2, 32'h0000_0200);
        tick();
        check("mask_hide", 32'(EIC_Vector), 32'd0);
        wr(3'd0, 32'h0000_0200);
        tick();
        check("mask_represent", 32'(EIC_Vector), 32'd10);
        rd(3'd5, d);
        check("status_read", d, 32'd10);

        // Rising edge on ch5 and acknowledge
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0000_0020);
        wr(3'd3, 32'h0000_0C00);
        tick();
        sig[5] = 1'b1;
        tick();
        sig = '0;
        tick();
        check("rise_vec_e1", 32'(EIC_Vector), 32'd0);
        rd(3'd1, d);
        check("rise_pend_pre", d, 32'd0);
        check("rise_vec_e2", 32'(EIC_Vector), 32'd0);
        rd(3'd1, d);
        check("rise_pend", d, 32'h0000_0020);
        check("rise_vec_e3", 32'(EIC_Vector), 32'd6);
        check("rise_int", 32'(EIC_Interrupt), 32'h0000_0006);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_old_vec", 32'(EIC_Vector), 32'd6);
        tick();
        check("ack_cleared", 32'(EIC_Vector), 32'd0);

        // Priority between ch3 and ch17, double ack in the hold cycle
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
        tick();
        sig = 32'h0002_0008;
        tick();
        sig = '0;
        repeat (3) tick();
        check("prio_vec", 32'(EIC_Vector), 32'd18);
        irq_ack = 1'b1;
        tick();
        check("prio_ack_hold", 32'(EIC_Vector), 32'd18);
        tick();
        irq_ack = 1'b0;
        check("prio_next", 32'(EIC_Vector), 32'd4);
        tick();
        check("prio_double_ack", 32'(EIC_Vector), 32'd4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        check("prio_empty", 32'(EIC_Vector), 32'd0);

        // Level-high flag cannot be cleared while asserted
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h0);
        sig[0] = 1'b1;
        repeat (4) tick();
        check("level_vec", 32'(EIC_Vector), 32'd1);
        wr(3'd1, 32'h1);
        rd(3'd1, d);
        check("level_stuck", d, 32'h1);
        sig = '0;
        repeat (3) tick();
        wr(3'd1, 32'h1);
        rd(3'd1, d);
        check("level_cleared", d, 32'h0);
        tick();
        check("level_vec_clear", 32'(EIC_Vector), 32'd0);

        // SET and ack of the same channel in one cycle: set wins
        wr(3'd2, 32'h0000_0080);
        tick();
        check("prec_vec", 32'(EIC_Vector), 32'd8);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = 3'd2;
        bus_if.reg_wdata = 32'h0000_0080;
        irq_ack          = 1'b1;
        tick();
        bus_if.reg_wr = 1'b0;
        irq_ack       = 1'b0;
        rd(3'd1, d);
        check("prec_pend", d, 32'h0000_0080);
        check("prec_vec_after", 32'(EIC_Vector), 32'd8);
        wr(3'd1, 32'hFFFF_FFFF);

        // Input held high across reset release must not look like an edge
        sig   = 32'h0000_0004;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        wr(3'd0, 32'h0000_0004);
        wr(3'd3, 32'h0000_0030);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("guard_vec_%0d", i), 32'(EIC_Vector), 32'd0);
        end
        rd(3'd1, d);
        check("guard_pend", d, 32'h0);
        sig = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eic_sense_bank.md
# eic_sense_bank

Parametrised second-generation external interrupt controller for the MIPSfpga+ system. It provides per-channel input synchronisation, a software-selectable sense mode per channel, a mask, and a pending register with software set and clear. A registered priority encoder drives the EIC processor interface, and an acknowledge input clears the serviced request. The block sits between raw board/peripheral interrupt lines and the core's EIC inputs; a simple word-addressed register port connects it to the bus bridge.

## Interface
- CHANNELS, 32, number of interrupt channels (1–32).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (1–3).
- CLK in 1, the single clock of the block.
- RESET in 1, synchronous, active-high reset.
- signal in CHANNELS, raw interrupt inputs.
- reg_wr in 1, register write strobe.
- reg_rd in 1, register read strobe.
- reg_addr in 3, word address of the register.
- reg_wdata in 32, write data.
- reg_rdata out 32, read data, registered.
- irq_ack in 1, the core accepts the currently presented vector.
- EIC_Interrupt out 8, {2'b00, EIC_Vector}.
- EIC_Vector out 6, winning channel index + 1; 0 means no request.

## Operation
- **Registers** (unused bits read 0, writes to them are ignored):
  - 0 MASK: rw; bit i enables channel i.
  - 1 PENDING: read gives pending flags; write-1-to-clear.
  - 2 SET: write-1-to-set pending; reads 0. Sets regardless of MASK.
  - 3 SENSE0: rw; 2 bits per channel for channels 0–15.
  - 4 SENSE1: rw; 2 bits per channel for channels 16–31.
  - 5 STATUS: read only; {26'b0, EIC_Vector}.
  - 6–7: read 0, writes ignored.
- **Sense codes:**
  - 00: level-high; event whenever the synchronised input is 1.
  - 01: any edge.
  - 10: falling edge.
  - 11: rising edge.
- **Per channel:**
  - sync is the last synchroniser stage.
  - prev holds sync delayed by one cycle; edges compare sync and prev.
  - event = MASK[i] & sense_match.
- **Pending update per cycle, highest precedence first:**
  - event or SET bit → 1.
  - PENDING W1C bit, or irq_ack with EIC_Vector == i+1 → 0.
  - Otherwise hold.
  - Consequence: a set always wins over a clear in the same cycle. A level-high channel whose input is still asserted cannot be cleared.
- **Encoder:** selects the highest i with PENDING[i] & MASK[i]. Registered output: EIC_Vector = i+1, or 0 if no channel qualifies.
- **Clearing MASK[i]** hides a pending channel but keeps its flag. Setting MASK[i] again re-presents it.
- **Writing SENSE** does not clear pending flags or the edge history. A mode change can therefore produce an event from the existing sync/prev pair on the next cycle.
- irq_ack while EIC_Vector == 0 is ignored.

## Timing
- **Reset values:** MASK, PENDING, SENSE0/1 = 0; reg_rdata = 0; EIC_Vector = 0; EIC_Interrupt = 0. All synchroniser stages and prev are 0.
- **Edge guard after reset:** edge detection is suppressed for the first SYNC_STAGES+1 cycles after RESET deasserts. No spurious edges while the pipeline fills.
- **Input latency:** signal stable before edge 0 reaches sync at edge SYNC_STAGES-1. PENDING sets at edge SYNC_STAGES, and EIC_Vector updates at edge SYNC_STAGES+1 (default: 3 cycles).
- **Register write:** takes effect at the edge where reg_wr is sampled. A SET or clear is visible on EIC_Vector one edge later.
- **Read:** reg_rdata is valid the cycle after reg_rd and holds until the next read. A read and a write to the same address in the same cycle return the pre-write value.
- **Acknowledge:** irq_ack clears the flag at the sampling edge. EIC_Vector shows the next winner one edge later. During that one cycle the old vector is still presented; a second irq_ack in that cycle clears nothing new because the flag is already 0.
- **Reset mid-operation:** RESET asserted during any activity returns all state to reset values at that edge. Inputs are ignored while RESET is high.

## Test plan
- **Reset defaults:** RESET high 2 cycles, then drive signal=32'hFFFF_FFFF with MASK=0 → EIC_Vector stays 0 and PENDING reads 0.
- **Rising edge and ack:** MASK=1<<5, SENSE0 ch5=11, pulse signal[5] for 1 cycle → PENDING=0x20 at +2 edges and EIC_Vector=6 at +3. irq_ack → EIC_Vector=0 after one edge.
- **Priority:** all channels rising-edge, MASK=all. Pulse channels 3 and 17 together → EIC_Vector=18. Ack → 4. Ack → 0.
- **Level-high cannot be cleared:** ch0 level-high, signal[0] held 1. W1C PENDING=1 → flag re-reads 1. Drop signal, then W1C → flag 0.
- **Same-cycle precedence:** a SET write of bit 7 together with irq_ack of vector 8 → PENDING[7] stays 1.
- **Post-reset glitch:** signal[2]=1 held across RESET deassertion with ch2 rising-edge → no pending during the guard window and no pending afterwards.
